// File: rtl/pll_lock_sequencer.sv
// Reset sequencer for a PLL: drives the PLL reset, qualifies lock, holds the
// system reset until lock is stable, re-arms on lock loss/timeout, latches a fault.
module pll_lock_sequencer #(
  parameter int RESET_HOLD    = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 256,
  parameter int GLITCH_FILTER = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       retry,
  output logic       pll_resetn,
  output logic       sys_reset,
  output logic       running,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
  localparam int MAX_CD = (STABLE_CYCLES > GLITCH_FILTER) ? STABLE_CYCLES : GLITCH_FILTER;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(GLITCH_FILTER - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_count_nxt;
  logic [7:0]       lock_loss_nxt;
  logic             locked_m, locked_s;

  assign state_dbg = state;

  // Two-flop synchroniser; locked is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + CNT_W'(1);
    retry_count_nxt = retry_count;
    lock_loss_nxt   = lock_loss_count;
    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retry_count == RETRY_LIMIT) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt       = ST_HOLD;
            retry_count_nxt = retry_count + 4'd1;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt       = ST_RUN;
          cnt_nxt         = '0;
          retry_count_nxt = 4'd0;
        end
      end
      ST_RUN: begin
        // Counter tracks the current run of unlocked samples only.
        if (locked_s) begin
          cnt_nxt = '0;
        end else if (cnt == GLITCH_LAST) begin
          state_nxt     = ST_HOLD;
          cnt_nxt       = '0;
          lock_loss_nxt = (lock_loss_count != 8'hFF) ? lock_loss_count + 8'd1
                                                     : lock_loss_count;
        end
      end
      ST_FAULT: begin
        cnt_nxt = '0;
        if (retry) begin
          state_nxt       = ST_HOLD;
          retry_count_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the transition edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_HOLD;
      cnt             <= '0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
      pll_resetn      <= 1'b0;
      sys_reset       <= 1'b1;
      running         <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_count     <= retry_count_nxt;
      lock_loss_count <= lock_loss_nxt;
      pll_resetn      <= !((state_nxt == ST_HOLD) || (state_nxt == ST_FAULT));
      sys_reset       <= (state_nxt != ST_RUN);
      running         <= (state_nxt == ST_RUN);
      fault           <= (state_nxt == ST_FAULT);
    end
  end

endmodule
